// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash write path.
// Holds the flash geometry, the feeder FSM state encoding and a small
// helper for sector-aligning addresses.
package spi_flash_pkg;

  localparam int SECTOR_BYTES = 4096;
  localparam int PAGE_BYTES   = 256;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_START     = 3'd2,
    ST_STREAM    = 3'd3,
    ST_WAIT_DONE = 3'd4
  } feeder_state_e;

  // Clear the in-sector offset bits so an address lands on a sector boundary.
  function automatic logic [31:0] sector_align(input logic [31:0] addr);
    return addr & ~32'(SECTOR_BYTES - 1);
  endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with first-word-fall-through head output.
// Ports:
//   clk_i, srst_i      clock, synchronous active-high reset
//   clr_i              synchronous clear (empties the FIFO)
//   push_i/push_data_i write one byte (ignored when full)
//   pop_i              drop the head byte (ignored when empty)
//   head_o             current head byte, 0 when empty
//   count_o            number of stored bytes (0..DEPTH)
//   full_o, empty_o    status flags
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_byte_fifo #(
  parameter int DEPTH = 4096,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          srst_i,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [7:0]    push_data_i,
  input  logic          pop_i,
  output logic [7:0]    head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q;
  logic [7:0]    head_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rd_ptr_d = rd_ptr_q + AW'(do_pop);

  // Storage array: no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Registered read of the *next* head address. When the byte being written
  // this cycle is the one that becomes the head (empty FIFO, or popping the
  // last byte while pushing), the RAM still returns stale data, so bypass.
  always_ff @(posedge clk_i) begin
    if (do_push && (wr_ptr_q == rd_ptr_d)) begin
      head_q <= push_data_i;
    end else begin
      head_q <= mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o = empty_o ? 8'h00 : head_q;

endmodule

// File: rtl/spi_flash_write_feeder.sv
// Upstream feeder for the flash write engine.
// Buffers an incoming byte stream into a sector-sized FIFO and launches one
// write job per buffer (full, flushed, or timed-out partial), streams the
// payload on the engine's per-byte request, then advances one sector.
// Ports:
//   system_clk, system_reset        clock, synchronous active-high reset
//   in_data/in_valid/in_ready       byte input handshake
//   flush                           force a job with the current partial buffer
//   cfg_addr/cfg_addr_load          base address load (IDLE only, sector aligned)
//   pi_flag                         one-cycle job start pulse
//   write_start_addr/write_num      job address and byte count, held for the job
//   write_data/data_req             FWFT payload byte and its consume strobe
//   write_finish                    engine job-complete pulse
//   busy                            job in progress
//   err                             sticky protocol error
module spi_flash_write_feeder
  import spi_flash_pkg::*;
#(
  parameter int          DEPTH       = SECTOR_BYTES,
  parameter int          TIMEOUT_CYC = 1000000,
  parameter logic [31:0] ADDR_LIMIT  = 32'h0100_0000
) (
  input  logic        system_clk,
  input  logic        system_reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  input  logic [31:0] cfg_addr,
  input  logic        cfg_addr_load,
  output logic        pi_flag,
  output logic [31:0] write_start_addr,
  output logic [15:0] write_num,
  output logic [7:0]  write_data,
  input  logic        data_req,
  input  logic        write_finish,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC);

  feeder_state_e state_q, state_d;
  logic [31:0]   cur_addr_q, cur_addr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   start_addr_q, start_addr_d;
  logic [15:0]   num_q, num_d;
  logic          err_q, err_d;

  logic          fifo_clr, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, count_next, count_after_pop;
  logic          accept, timeout_hit;
  logic [32:0]   addr_sum;
  logic [31:0]   adv_addr;

  assign in_ready = !system_reset && !fifo_full &&
                    ((state_q == ST_IDLE) || (state_q == ST_FILL));
  assign accept   = in_valid && in_ready;

  // Occupancy including a byte accepted this cycle (no pop while filling).
  assign count_next      = fifo_count + CW'(accept);
  assign count_after_pop = fifo_count - CW'(fifo_pop);
  assign timeout_hit     = (timer_q == TW'(TIMEOUT_CYC - 1));

  // Every job consumes a whole sector because the engine erases it up front.
  // The sum is one bit wider so a limit near 4 GB cannot wrap silently.
  assign addr_sum = {1'b0, cur_addr_q} + 33'(DEPTH);
  assign adv_addr = (addr_sum >= {1'b0, ADDR_LIMIT}) ? 32'h0 : addr_sum[31:0];

  sync_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (system_clk),
    .srst_i      (system_reset),
    .clr_i       (fifo_clr),
    .push_i      (accept),
    .push_data_i (in_data),
    .pop_i       (fifo_pop),
    .head_o      (write_data),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    timer_d      = timer_q;
    start_addr_d = start_addr_q;
    num_d        = num_q;
    err_d        = err_q;
    fifo_pop     = 1'b0;
    fifo_clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (cfg_addr_load) begin
          cur_addr_d = sector_align(cfg_addr);
        end
        if (accept) begin
          if ((count_next == CW'(DEPTH)) || flush) begin
            state_d      = ST_START;
            start_addr_d = cur_addr_d;
            num_d        = 16'(count_next);
          end else begin
            state_d = ST_FILL;
          end
        end
      end

      ST_FILL: begin
        timer_d = accept ? '0 : timer_q + TW'(1);
        if ((count_next == CW'(DEPTH)) ||
            (flush && (count_next != '0)) ||
            (!accept && timeout_hit)) begin
          state_d      = ST_START;
          timer_d      = '0;
          start_addr_d = cur_addr_q;
          num_d        = 16'(count_next);
        end
      end

      ST_START: begin
        state_d = ST_STREAM;
      end

      ST_STREAM: begin
        fifo_pop = data_req && !fifo_empty;
        if (data_req && fifo_empty) begin
          err_d = 1'b1;
        end
        if (write_finish) begin
          // Early finish abandons the rest of the payload but still
          // consumes the sector.
          if (count_after_pop != '0) begin
            err_d    = 1'b1;
            fifo_clr = 1'b1;
          end
          cur_addr_d = adv_addr;
          state_d    = ST_IDLE;
        end else if (count_after_pop == '0) begin
          state_d = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        if (data_req) begin
          err_d = 1'b1;
        end
        if (write_finish) begin
          cur_addr_d = adv_addr;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge system_clk) begin
    if (system_reset) begin
      state_q      <= ST_IDLE;
      cur_addr_q   <= '0;
      timer_q      <= '0;
      start_addr_q <= '0;
      num_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      timer_q      <= timer_d;
      start_addr_q <= start_addr_d;
      num_q        <= num_d;
      err_q        <= err_d;
    end
  end

  assign pi_flag          = (state_q == ST_START);
  assign busy             = (state_q == ST_START) || (state_q == ST_STREAM) ||
                            (state_q == ST_WAIT_DONE);
  assign write_start_addr = start_addr_q;
  assign write_num        = num_q;
  assign err              = err_q;

endmodule

// File: tb/tb_spi_flash_write_feeder.sv
// Directed self-checking bench for spi_flash_write_feeder.
module tb_spi_flash_write_feeder;
  import spi_flash_pkg::*;

  logic        clk = 1'b0;
  logic        system_reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [31:0] cfg_addr = 32'h0;
  logic        cfg_addr_load = 1'b0;
  logic        pi_flag;
  logic [31:0] write_start_addr;
  logic [15:0] write_num;
  logic [7:0]  write_data;
  logic        data_req = 1'b0;
  logic        write_finish = 1'b0;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  spi_flash_write_feeder #(
    .DEPTH       (4096),
    .TIMEOUT_CYC (50),
    .ADDR_LIMIT  (32'h0100_0000)
  ) dut (
    .system_clk       (clk),
    .system_reset     (system_reset),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .flush            (flush),
    .cfg_addr         (cfg_addr),
    .cfg_addr_load    (cfg_addr_load),
    .pi_flag          (pi_flag),
    .write_start_addr (write_start_addr),
    .write_num        (write_num),
    .write_data       (write_data),
    .data_req         (data_req),
    .write_finish     (write_finish),
    .busy             (busy),
    .err              (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_pi_flag"}, 32'(pi_flag), 32'd0);
    check({tag, "_addr"}, write_start_addr, 32'd0);
    check({tag, "_num"}, 32'(write_num), 32'd0);
    check({tag, "_wdata"}, 32'(write_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic push_bytes(input int n, input logic [7:0] base);
    int w;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      w = 0;
      while (!in_ready && w < 100) begin
        tick();
        w++;
      end
      if (w == 100) check("in_ready_wait", 32'(in_ready), 32'd1);
      tick();
      exp_q.push_back(in_data);
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic expect_job(input logic [31:0] addr, input int num);
    int n;
    n = 0;
    while (pi_flag !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("pi_flag_seen", 32'(pi_flag), 32'd1);
    check("job_addr", write_start_addr, addr);
    check("job_num", 32'(write_num), 32'(num));
    check("busy_start", 32'(busy), 32'd1);
    $display("JOB addr=%h num=%0d", write_start_addr, write_num);
    tick();
    check("pi_flag_pulse", 32'(pi_flag), 32'd0);
  endtask

  task automatic drain(input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      check("wdata", 32'(write_data), 32'(e));
      data_req = 1'b1;
      tick();
    end
    data_req = 1'b0;
  endtask

  task automatic finish_job();
    write_finish = 1'b1;
    tick();
    write_finish = 1'b0;
    check("busy_after_finish", 32'(busy), 32'd0);
    check("in_ready_after_finish", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;

    // Reset
    tick();
    tick();
    check_reset_outputs("reset");
    system_reset = 1'b0;
    tick();
    check("in_ready_idle", 32'(in_ready), 32'd1);

    // Full sector job
    push_bytes(4096, 8'h00);
    check("in_ready_full", 32'(in_ready), 32'd0);
    expect_job(32'h0000_0000, 4096);
    drain(4096);
    check("full_state_wait", 32'(dut.state_q), 32'(ST_WAIT_DONE));
    check("full_wdata_empty", 32'(write_data), 32'd0);
    finish_job();
    check("full_err", 32'(err), 32'd0);

    // Flush of a partial buffer
    push_bytes(10, 8'hA0);
    pulse_flush();
    expect_job(32'h0000_1000, 10);
    drain(10);
    check("flush_state_wait", 32'(dut.state_q), 32'(ST_WAIT_DONE));
    check("flush_wdata_empty", 32'(write_data), 32'd0);
    check("flush_busy", 32'(busy), 32'd1);
    finish_job();

    // Flush with empty buffer is ignored
    pulse_flush();
    tick();
    check("empty_flush_busy", 32'(busy), 32'd0);

    // Timeout forcing a partial job
    push_bytes(3, 8'h31);
    n = 0;
    while (pi_flag !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("timeout_cycles", 32'(n), 32'd50);
    expect_job(32'h0000_2000, 3);
    drain(3);
    finish_job();

    // Address load and wrap at the flash limit
    cfg_addr = 32'h00FF_F123;
    cfg_addr_load = 1'b1;
    tick();
    cfg_addr_load = 1'b0;
    push_bytes(5, 8'h50);
    pulse_flush();
    cfg_addr = 32'h0012_3456;
    expect_job(32'h00FF_F000, 5);
    cfg_addr_load = 1'b1;
    drain(5);
    cfg_addr_load = 1'b0;
    check("addr_stable", write_start_addr, 32'h00FF_F000);
    finish_job();
    push_bytes(2, 8'h60);
    pulse_flush();
    expect_job(32'h0000_0000, 2);
    drain(2);
    finish_job();

    // Error: data_req after drain
    push_bytes(4, 8'h70);
    pulse_flush();
    expect_job(32'h0000_1000, 4);
    drain(4);
    check("err_before_extra_req", 32'(err), 32'd0);
    data_req = 1'b1;
    tick();
    data_req = 1'b0;
    check("err_extra_req", 32'(err), 32'd1);
    finish_job();
    check("err_sticky", 32'(err), 32'd1);

    // Reset clears the sticky error
    system_reset = 1'b1;
    tick();
    check_reset_outputs("reset2");
    system_reset = 1'b0;
    tick();

    // Error: early write_finish with 5 bytes left
    push_bytes(8, 8'h80);
    pulse_flush();
    expect_job(32'h0000_0000, 8);
    drain(3);
    write_finish = 1'b1;
    tick();
    write_finish = 1'b0;
    exp_q.delete();
    check("early_fin_err", 32'(err), 32'd1);
    check("early_fin_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("early_fin_busy", 32'(busy), 32'd0);
    check("early_fin_wdata", 32'(write_data), 32'd0);
    check("early_fin_in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of a stream
    push_bytes(6, 8'h90);
    pulse_flush();
    expect_job(32'h0000_1000, 6);
    drain(2);
    system_reset = 1'b1;
    tick();
    check_reset_outputs("reset_mid");
    system_reset = 1'b0;
    exp_q.delete();
    tick();
    push_bytes(3, 8'hC0);
    pulse_flush();
    expect_job(32'h0000_0000, 3);
    drain(3);
    finish_job();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
